// File: rtl/seq_detect_pkg.sv
// Shared constants for the parametrised serial pattern detector: legal parameter
// ranges, default pattern and overlap-mode encoding.
package seq_detect_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    localparam logic [3:0] DEF_PATTERN = 4'b1010;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial sample, configuration and match-strobe bundle for seq_detect_param.
interface seq_detect_param_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             i;
    logic             in_valid;
    logic             cfg_load;
    logic [WIDTH-1:0] cfg_pattern;
    logic [WIDTH-1:0] cfg_mask;
    logic             cfg_overlap;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output i, in_valid, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
        input  y, match_cnt
    );

    modport slave (
        input  i, in_valid, cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
        output y, match_cnt
    );
endinterface

// File: rtl/seq_detect_hist.sv
// History shift register and saturating fill counter; fill is the detector state.
//   state          | meaning
//   fill = 0..W-2  | FILL_n: fewer than WIDTH-1 bits collected since restart
//   fill = W-1     | ARMED: history holds WIDTH-1 valid bits, compare enabled
module seq_detect_hist #(
    parameter int WIDTH = 4,
    parameter int FW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             restart,
    input  logic             din,
    output logic [WIDTH-2:0] hist,
    output logic [FW-1:0]    fill
);
    localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH - 1);

    logic [WIDTH-1:0] cat;
    assign cat = {hist, din};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= cat[WIDTH-2:0];
            if (restart)
                fill <= '0;
            else if (fill != FILL_MAX)
                fill <= fill + FW'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime pattern/mask/overlap and a Mealy
// match strobe. Optional saturating match counter: SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RST_PATTERN = WIDTH'(DEF_PATTERN),
    parameter int               CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int FW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_check
        $error("seq_detect_param: WIDTH or CNT_W out of legal range");
    end

    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] msk;
    logic             ovl;
    logic [WIDTH-2:0] hist;
    logic [FW-1:0]    fill;
    logic             accept;
    logic             armed;
    logic             hit;
    logic             y;

    assign accept = bus.in_valid & ~bus.cfg_load;
    assign armed  = (fill == FW'(WIDTH - 1));
    assign hit    = (({hist, bus.i} ^ pat) & msk) == '0;
    assign y      = accept & armed & hit;
    assign bus.y  = y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat <= RST_PATTERN;
            msk <= '1;
            ovl <= OVL_OFF;
        end else if (bus.cfg_load) begin
            pat <= bus.cfg_pattern;
            msk <= bus.cfg_mask;
            ovl <= bus.cfg_overlap;
        end
    end

    seq_detect_hist #(.WIDTH(WIDTH), .FW(FW)) u_hist (
        .clk     (clk),
        .rst     (rst),
        .shift   (accept),
        .clear   (bus.cfg_load),
        .restart (y & (ovl == OVL_OFF)),
        .din     (bus.i),
        .hist    (hist),
        .fill    (fill)
    );

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (bus.cfg_load)
            cnt <= '0;
        else if (y && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign bus.match_cnt = cnt;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (WIDTH=4, CNT_W=2).
module tb_seq_detect_param;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    seq_detect_param_if #(.WIDTH(4), .CNT_W(2)) bus ();

    seq_detect_param #(.WIDTH(4), .RST_PATTERN(4'b1010), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] ec(input int n);
        logic [1:0] sat;
        sat = (n > 3) ? 2'd3 : 2'(n);
        return CNT_EN ? sat : 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits/exp are MSB-first: bit n-1 is presented first
    task automatic run(input logic [15:0] bits, input logic [15:0] exp, input int n,
                       input string tag);
        for (int k = n - 1; k >= 0; k--) begin
            @(negedge clk);
            bus.cfg_load = 1'b0;
            bus.in_valid = 1'b1;
            bus.i        = bits[k];
            #1 chk($sformatf("%s_y[%0d]", tag, n - 1 - k), 32'(bus.y), 32'(exp[k]));
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.cfg_load = 1'b0;
            bus.in_valid = 1'b0;
            bus.i        = k[0];
            #1 chk($sformatf("%s_gap[%0d]", tag, k), 32'(bus.y), 32'd0);
            @(posedge clk);
        end
    endtask

    task automatic cfg(input logic [3:0] p, input logic [3:0] m, input logic o,
                       input string tag);
        @(negedge clk);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_mask    = m;
        bus.cfg_overlap = o;
        bus.in_valid    = 1'b1;
        bus.i           = 1'b1;
        #1 chk({tag, "_cfg_y"}, 32'(bus.y), 32'd0);
        @(posedge clk);
        #1 chk({tag, "_cfg_cnt"}, 32'(bus.match_cnt), 32'd0);
    endtask

    task automatic chk_cnt(input string tag, input int n);
        #1 chk({tag, "_cnt"}, 32'(bus.match_cnt), 32'(ec(n)));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst             = 1'b0;
        bus.i           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = 4'h0;
        bus.cfg_mask    = 4'h0;
        bus.cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        bus.in_valid = 1'b1;
        bus.i        = 1'b0;
        #1 chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;

        // reset defaults: 1010, non-overlap
        run(16'b10101010, 16'b00010001, 8, "t1");
        chk_cnt("t1", 2);

        cfg(4'b1010, 4'b1111, 1'b1, "t2");
        run(16'b101010, 16'b000101, 6, "t2");
        chk_cnt("t2", 2);

        cfg(4'b1010, 4'b1111, 1'b0, "t3");
        run(16'b101, 16'b000, 3, "t3a");
        idle(3, "t3");
        run(16'b0, 16'b1, 1, "t3b");
        chk_cnt("t3", 1);

        run(16'b101, 16'b000, 3, "t4a");
        cfg(4'b1100, 4'b1111, 1'b0, "t4");
        run(16'b0, 16'b0, 1, "t4b");
        run(16'b1100, 16'b0001, 4, "t4c");
        chk_cnt("t4", 1);

        cfg(4'b1001, 4'b1001, 1'b1, "t5");
        run(16'b1111, 16'b0001, 4, "t5a");
        run(16'b111, 16'b111, 3, "t5b");
        chk_cnt("t5", 4);

        cfg(4'b0000, 4'b0000, 1'b1, "t6");
        run(16'b10010110, 16'b00011111, 8, "t6");
        chk_cnt("t6", 5);

        // async reset while a match is being presented
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.i        = 1'b0;
        #1 chk("t7_pre_y", 32'(bus.y), 32'd1);
        rst = 1'b0;
        #1 chk("t7_rst_y", 32'(bus.y), 32'd0);
        chk("t7_rst_cnt", 32'(bus.match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(16'b1010, 16'b0001, 4, "t7");
        chk_cnt("t7", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
